twiddle_rom_cmult_ifft: RTL
===========================

// Module: twiddle_rom_cmult_ifft
// PURPOSE
// - Consumer of the per-row twiddle index produced by the IFFT address generators.
// - Looks up the IFFT twiddle W = exp(+j*2*pi*k/NFFT) for index k and multiplies the
//   streamed complex sample by W.
// - Sits between an SDF butterfly stage and the next stage of the 64-point mixed-radix IFFT.
// - Fixed 3-cycle pipeline, no backpressure. Tracks frames of NFFT output samples.
// PARAMETERS
// - NFFT    64  transform size; twiddle ROM depth; index width is log2(NFFT)=6
// - DATA_W  16  signed two's-complement width of each data component (in and out)
// - TW_W    16  signed twiddle width, format Q1.(TW_W-1)
// PORTS
// - clk              in   1       clock, rising edge
// - rst              in   1       asynchronous reset, active-low
// - in_valid         in   1       in_re/in_im/Twiddle_address valid this cycle
// - in_re            in   DATA_W  input sample, real part
// - in_im            in   DATA_W  input sample, imaginary part
// - Twiddle_address  in   6       twiddle index k, same cycle as the sample
// - out_valid        out  1       out_re/out_im valid
// - out_re           out  DATA_W  product, real part
// - out_im           out  DATA_W  product, imaginary part
// - out_last         out  1       high with the NFFT-th valid output of a frame
// BEHAVIOUR
// - Reset (rst=0, async): out_valid=0, out_last=0, out_re=0, out_im=0.
//   Reset also clears all pipeline valid bits and the frame counter. Data regs may clear too.
// - ROM: cos_rom[k] and sin_rom[k] hold round(x*2^(TW_W-1)) with x=cos/sin(2*pi*k/NFFT).
//   Values are clipped to [-2^(TW_W-1), 2^(TW_W-1)-1]: +1.0 -> 32767, -1.0 -> -32768.
//   Sign is positive (IFFT convention), so k=16 gives W = +j.
// - Pipeline: every valid input produces exactly one output. Latency 3 cycles, throughput 1/clk.
//   - S1: register sample, valid bit, and bypass flag (k==0); register ROM outputs c, s.
//   - S2: register four signed products: re*c, im*s, re*s, im*c (DATA_W+TW_W bits each).
//   - S3: form P_re = re*c - im*s and P_im = re*s + im*c (DATA_W+TW_W+1 bits).
//     Round: add 2^(TW_W-2), then arithmetic shift right by TW_W-1.
//     Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register.
//   - k==0 bypass: out = input sample unchanged (exact unity), still 3 cycles.
// - Bubbles: in_valid=0 propagates as out_valid=0 three cycles later.
//   The pipeline never stalls. out_re/out_im hold their last value while out_valid=0.
// - State machine (frame tracker on the output side):
//   - IDLE: cnt=0. The first out_valid moves to RUN with cnt=1.
//   - RUN: each out_valid increments cnt. The beat with cnt==NFFT-1 asserts out_last,
//     then cnt wraps to 0 and the state goes to IDLE.
//   - out_valid=0 in RUN holds cnt (gaps allowed mid-frame).
//   - Back-to-back frames: IDLE exits on the same cycle as the next out_valid, with no lost beat.
// - out_last is registered with out_valid/out_re/out_im (same cycle); out_last=0 when out_valid=0.
// - Twiddle_address is ignored when in_valid=0. All 6-bit values are legal indices.
// - Reset mid-frame discards in-flight samples. After release, the next valid output is frame beat 0.
// TESTING
// - k=0, in=(1000,-2000), single valid -> out_valid exactly 3 clks later, out=(1000,-2000).
// - k=16 (W=+j), in=(16384,0) -> out=(0,16384); k=32 (W=-1), in=(16384,8192) -> out=(-16384,-8192).
// - Saturation: k=32, in=(-32768,0) -> out_re=32767 (clipped), out_im=0.
// - 64 consecutive valids with k=0..63, including random-gap variant -> 64 outputs match a golden
//   model bit-exactly (|err|<=1 LSB vs float). out_last only on the 64th output.
// - Two frames back-to-back with no gap -> out_last on outputs 64 and 128, with no dropped or
//   duplicated beats.
// - Assert rst=0 after 20 samples of a frame -> outputs 0 immediately; no in-flight sample
//   emerges. Then 64 new valids -> out_last on the 64th.

Source files
------------

// File: rtl/twiddle_rom_cmult_ifft.sv
// IFFT twiddle multiplier: W = exp(+j*2*pi*k/NFFT) from a quarter-wave ROM, 3-cycle pipeline,
// with an output-side frame tracker flagging the last beat of each NFFT-sample frame.
module twiddle_rom_cmult_ifft #(
    parameter int NFFT   = 64,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_re,
    input  logic [DATA_W-1:0]       in_im,
    input  logic [$clog2(NFFT)-1:0] Twiddle_address,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_re,
    output logic [DATA_W-1:0]       out_im,
    output logic                    out_last
);
    localparam int AW = $clog2(NFFT);
    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] RND = SW'(1) << (TW_W - 2);

    typedef enum logic {IDLE, RUN} state_t;

    // Quarter-wave cosine magnitude in Q1.15 for NFFT=64; index 0 is the unclipped +1.0.
    function automatic logic signed [TW_W:0] qmag(input logic [4:0] m);
        int v;
        case (m)
            5'd0:    v = 32768;
            5'd1:    v = 32610;
            5'd2:    v = 32138;
            5'd3:    v = 31357;
            5'd4:    v = 30274;
            5'd5:    v = 28899;
            5'd6:    v = 27246;
            5'd7:    v = 25330;
            5'd8:    v = 23170;
            5'd9:    v = 20788;
            5'd10:   v = 18205;
            5'd11:   v = 15447;
            5'd12:   v = 12540;
            5'd13:   v = 9512;
            5'd14:   v = 6393;
            5'd15:   v = 3212;
            default: v = 0;
        endcase
        return (TW_W+1)'(v);
    endfunction

    function automatic logic [TW_W-1:0] clip_tw(input logic signed [TW_W:0] x);
        if (!x[TW_W] && x[TW_W-1]) return {1'b0, {(TW_W-1){1'b1}}};
        else return x[TW_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
        if (&x[SW-1:DATA_W-1] || ~|x[SW-1:DATA_W-1]) return x[DATA_W-1:0];
        else if (x[SW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
        else return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    logic [4:0]              ma, mb;
    logic signed [TW_W:0]    c_full, s_full;

    // Quadrant folding: cos/sin of quadrant q derived from cos(r) and cos(16-r).
    always_comb begin
        ma     = {1'b0, Twiddle_address[3:0]};
        mb     = 5'd16 - ma;
        c_full = '0;
        s_full = '0;
        case (Twiddle_address[5:4])
            2'd0: begin c_full =  qmag(ma); s_full =  qmag(mb); end
            2'd1: begin c_full = -qmag(mb); s_full =  qmag(ma); end
            2'd2: begin c_full = -qmag(ma); s_full = -qmag(mb); end
            default: begin c_full = qmag(mb); s_full = -qmag(ma); end
        endcase
    end

    logic              v1_q, byp1_q;
    logic [DATA_W-1:0] re1_q, im1_q;
    logic [TW_W-1:0]   c1_q, s1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0; byp1_q <= 1'b0;
            re1_q <= '0; im1_q <= '0; c1_q <= '0; s1_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                re1_q  <= in_re;
                im1_q  <= in_im;
                byp1_q <= (Twiddle_address == '0);
                c1_q   <= clip_tw(c_full);
                s1_q   <= clip_tw(s_full);
            end
        end
    end

    logic                 v2_q, byp2_q;
    logic [DATA_W-1:0]    re2_q, im2_q;
    logic signed [PW-1:0] prc_q, pis_q, prs_q, pic_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_q <= 1'b0; byp2_q <= 1'b0; re2_q <= '0; im2_q <= '0;
            prc_q <= '0; pis_q <= '0; prs_q <= '0; pic_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                byp2_q <= byp1_q;
                re2_q  <= re1_q;
                im2_q  <= im1_q;
                prc_q  <= $signed(re1_q) * $signed(c1_q);
                pis_q  <= $signed(im1_q) * $signed(s1_q);
                prs_q  <= $signed(re1_q) * $signed(s1_q);
                pic_q  <= $signed(im1_q) * $signed(c1_q);
            end
        end
    end

    logic signed [SW-1:0] pre_re_d, pre_im_d, sh_re_d, sh_im_d;
    logic [DATA_W-1:0]    res_re_d, res_im_d;

    always_comb begin
        pre_re_d = {prc_q[PW-1], prc_q} - {pis_q[PW-1], pis_q} + RND;
        pre_im_d = {prs_q[PW-1], prs_q} + {pic_q[PW-1], pic_q} + RND;
        sh_re_d  = pre_re_d >>> (TW_W - 1);
        sh_im_d  = pre_im_d >>> (TW_W - 1);
        res_re_d = byp2_q ? re2_q : sat(sh_re_d);
        res_im_d = byp2_q ? im2_q : sat(sh_im_d);
    end

    state_t            state_q;
    logic [AW-1:0]     cnt_q;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_re_q, out_im_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            out_valid_q <= v2_q;
            out_last_q  <= 1'b0;
            if (v2_q) begin
                out_re_q <= res_re_d;
                out_im_q <= res_im_d;
                case (state_q)
                    IDLE: begin
                        cnt_q   <= AW'(1);
                        state_q <= RUN;
                    end
                    default: begin
                        if (cnt_q == AW'(NFFT - 1)) begin
                            out_last_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + AW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
endmodule
